imem_prefetch: RTL

IMEM_PREFETCH -- requirements
Module: imem_prefetch

---
 rtl/rvcpu_pkg.sv | 17 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/imem_prefetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rvcpu_pkg.sv
// rvcpu: shared core-wide types for the fetch path.
//   Width         - default instruction/address width in bits
//   addr_t/data_t - address and instruction word types at the default width
//   fetch_entry_t - one fetched instruction together with its address
package rvcpu;

  localparam int unsigned Width = 32;

  typedef logic [Width-1:0] addr_t;
  typedef logic [Width-1:0] data_t;

  typedef struct packed {
    addr_t pc;
    data_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a type parameter for the element.
// Parameters: Depth (power of two, >= 2), T (element type).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_flush         empties the FIFO on the next edge (wins over push/pop)
//   i_push, i_data  write i_data at the tail; accepted when full only if popping too
//   i_pop           remove the head entry; ignored when empty
//   o_data          current head entry (storage resets to zero)
//   o_count         number of valid entries, 0..Depth
module sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter type T = logic [31:0]
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_data,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthW = (PtrW + 1)'(Depth);

  T                r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  always_comb begin
    w_full    = (r_count == DepthW);
    w_empty   = (r_count == '0);
    w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/imem_prefetch.sv
// imem_prefetch: instruction prefetcher between an in-order instruction memory and the core.
// Issues sequential fetches, tags each with its address in an in-order queue, buffers returned
// words in a FIFO and discards responses that belong to fetches made before a redirect.
// Optional feature: define PREFETCH_BYPASS_EN to present a returning word to the core in the
// same cycle when the FIFO is empty.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_mem_addr, o_mem_valid        fetch request; accepted when i_mem_ready is high
//   i_mem_ready                    memory accepts the request this cycle
//   i_mem_data, i_mem_done         returned word, in request order
//   o_instr, o_instr_pc            instruction and its address presented to the core
//   o_instr_valid, i_instr_ready   core handshake; head leaves when both are high
//   i_redirect, i_redirect_pc      flush and restart fetching at i_redirect_pc (word aligned)
module imem_prefetch
  import rvcpu::*;
#(
  parameter int unsigned       Width   = rvcpu::Width,
  parameter int unsigned       Depth   = 4,
  parameter logic [Width-1:0]  ResetPc = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [Width-1:0] o_mem_addr,
  output logic             o_mem_valid,
  input  logic             i_mem_ready,
  input  logic [Width-1:0] i_mem_data,
  input  logic             i_mem_done,
  output logic [Width-1:0] o_instr,
  output logic [Width-1:0] o_instr_pc,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  input  logic             i_redirect,
  input  logic [Width-1:0] i_redirect_pc
);

  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(Depth);

  typedef struct packed {
    logic [Width-1:0] pc;
    logic [Width-1:0] instr;
  } entry_t;

  logic [Width-1:0] r_pc;
  logic [CntW-1:0]  r_outst;
  logic [CntW-1:0]  r_drop;

  logic [Width-1:0] w_pc_d;
  logic [CntW-1:0]  w_outst_d;
  logic [CntW-1:0]  w_drop_d;
  logic [CntW:0]    w_inflight;
  logic             w_mem_valid;
  logic             w_accept;
  logic             w_done_ok;
  logic             w_drop_hit;
  logic             w_keep;
  logic [Width-1:0] w_tag_pc;
  logic [CntW-1:0]  w_tag_count;
  logic [CntW-1:0]  w_fifo_count;
  logic             w_fifo_nonempty;
  logic             w_push;
  logic             w_pop;
  entry_t           w_entry_in;
  entry_t           w_head;

  // Fetches that are in flight still own a FIFO slot, so a response always has room.
  always_comb begin
    w_inflight      = {1'b0, w_fifo_count} + {1'b0, r_outst};
    w_mem_valid     = i_rst_n && !i_redirect && (w_inflight < DepthW);
    w_accept        = w_mem_valid && i_mem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    w_done_ok       = i_mem_done && (r_outst != '0);
    w_drop_hit      = w_done_ok && (r_drop != '0);
    w_keep          = w_done_ok && (r_drop == '0) && !i_redirect;
    w_fifo_nonempty = (w_fifo_count != '0);
    w_entry_in      = '{pc: w_tag_pc, instr: i_mem_data};
  end

  always_comb begin
    w_pc_d = r_pc;
    if (i_redirect) begin
      w_pc_d = {i_redirect_pc[Width-1:2], 2'b00};
    end else if (w_accept) begin
      w_pc_d = r_pc + Width'(4);
    end

    w_outst_d = r_outst;
    if (w_accept && !w_done_ok) begin
      w_outst_d = r_outst + 1'b1;
    end else if (!w_accept && w_done_ok) begin
      w_outst_d = r_outst - 1'b1;
    end

    // Every fetch still outstanding after this cycle predates the redirect and must be
    // discarded; an earlier pending drop count is already included in r_outst.
    w_drop_d = r_drop;
    if (i_redirect) begin
      w_drop_d = r_outst - CntW'(w_done_ok);
    end else if (w_drop_hit) begin
      w_drop_d = r_drop - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= ResetPc;
      r_outst <= '0;
      r_drop  <= '0;
    end else begin
      r_pc    <= w_pc_d;
      r_outst <= w_outst_d;
      r_drop  <= w_drop_d;
    end
  end

`ifdef PREFETCH_BYPASS_EN
  logic w_bypass;

  always_comb begin
    w_bypass      = !w_fifo_nonempty && w_keep;
    // A bypassed word that the core takes right away never enters the FIFO.
    w_push        = w_keep && !(w_bypass && i_instr_ready);
    w_pop         = w_fifo_nonempty && i_instr_ready;
    o_instr_valid = w_fifo_nonempty || w_bypass;
    o_instr       = w_bypass ? i_mem_data : w_head.instr;
    o_instr_pc    = w_bypass ? w_tag_pc : w_head.pc;
  end
`else
  always_comb begin
    w_push        = w_keep;
    w_pop         = w_fifo_nonempty && i_instr_ready;
    o_instr_valid = w_fifo_nonempty;
    o_instr       = w_head.instr;
    o_instr_pc    = w_head.pc;
  end
`endif

  assign o_mem_addr  = r_pc;
  assign o_mem_valid = w_mem_valid;

  // Addresses of live (non-dropped) fetches, oldest first.
  sync_fifo #(
    .Depth (Depth),
    .T     (logic [Width-1:0])
  ) u_tag_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_accept),
    .i_data  (r_pc),
    .i_pop   (w_keep),
    .o_data  (w_tag_pc),
    .o_count (w_tag_count)
  );

  sync_fifo #(
    .Depth (Depth),
    .T     (entry_t)
  ) u_instr_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!i_mem_done || (r_outst != '0));
      assert (({1'b0, w_tag_count} + {1'b0, r_drop}) == {1'b0, r_outst});
    end
  end
`endif

endmodule
